apb_xfer_controller: RTL
========================

// Module: apb_xfer_controller
// PURPOSE
//  Sequences APB transfers for the AHB-to-APB bridge. Accepts single read/write
//  commands from the bridge's AHB-side slave over a valid/ready port, decodes the
//  address to one of 4 APB slaves and drives SETUP/ACCESS phases on the APB bus
//  (PSELx/PENABLE/PADDR/PWRITE/PWDATA, PRDATA in). Returns read data or a decode
//  error on a response port. APB has no PREADY/PSLVERR: every ACCESS is one cycle.
// PARAMETERS
//  BASE_ADDR  32'h8000_0000  start of APB window
//  SLV_SHIFT  26             log2 of slave region size (64 MB per slave)
//  NUM_SLV    4              number of PSELx lines (fixed 4, width of PSELx)
// PORTS
//  clock      in   1   single clock, all flops on posedge
//  Hresetn    in   1   asynchronous, active-low reset
//  req_valid  in   1   command valid
//  req_ready  out  1   controller can accept command this cycle
//  req_write  in   1   1 = write, 0 = read
//  req_addr   in   32  byte address
//  req_wdata  in   32  write data (ignored for reads)
//  rsp_valid  out  1   one-cycle response pulse; consumer always accepts
//  rsp_err    out  1   valid with rsp_valid: address outside APB window
//  rsp_rdata  out  32  read data valid with rsp_valid; 0 for writes/errors
//  PADDR      out  32  APB address
//  PWRITE     out  1   APB direction
//  PWDATA     out  32  APB write data
//  PSELx      out  4   one-hot APB slave select
//  PENABLE    out  1   APB access phase
//  PRDATA     in   32  APB read data, sampled at end of ACCESS
// BEHAVIOUR
//  Reset (async, Hresetn=0): state=IDLE; PSELx=0, PENABLE=0 immediately; PADDR,
//   PWDATA, rsp_rdata=0; PWRITE, rsp_valid, rsp_err=0; req_ready=1 after release.
//  Accept = req_valid & req_ready at posedge. req_ready = state in {IDLE,ACCESS,ERR}
//   (combinational from state; 0 in SETUP).
//  Decode: idx = (req_addr-BASE_ADDR)>>SLV_SHIFT; hit iff BASE_ADDR <=
//   req_addr < BASE_ADDR + NUM_SLV<<SLV_SHIFT (compare unsigned 33-bit, no wrap).
//  FSM (registered outputs, all updated on the accepting edge):
//   IDLE  : accept&hit -> SETUP (PADDR/PWRITE/PWDATA loaded, PSELx=1<<idx,
//           PENABLE=0); accept&miss -> ERR; else stay.
//   SETUP : -> ACCESS, PENABLE=1; PADDR/PWRITE/PWDATA/PSELx unchanged.
//   ACCESS: PENABLE=0 on exit; rsp_valid=1 next cycle, rsp_rdata=PRDATA if read,
//           else 0; accept&hit -> SETUP (new PSELx, back-to-back, no idle cycle);
//           accept&miss -> ERR (PSELx=0); no accept -> IDLE (PSELx=0).
//   ERR   : no APB activity; rsp_valid=1,rsp_err=1 next cycle; accept as IDLE.
//  Latency: accept edge T -> SETUP cycle T+1 -> ACCESS T+2 -> rsp_valid T+3.
//   Decode error: accept T -> ERR T+1 -> rsp_valid/rsp_err T+2.
//  Throughput: one APB transfer per 2 cycles; responses never collide (one
//   response-producing state per cycle).
//  PADDR/PWRITE/PWDATA hold last value in IDLE/ERR (no toggling); PWDATA loaded
//   on reads too (value don't-care). Stable from SETUP through ACCESS.
//  rsp_valid is a single-cycle pulse; rsp_err=0 for all APB transfers.
//  Reset mid-transfer: transfer abandoned, no response; PSELx/PENABLE drop
//   asynchronously.
//  req_* inputs not sampled when req_ready=0; changes there are ignored.
// STRUCTURE
//  Package apb_ctrl_pkg: typedef enum logic[1:0] {IDLE,SETUP,ACCESS,ERR}
//   apb_state_e; localparams NUM_SLV=4, default BASE_ADDR, SLV_SHIFT.
//  Sub-module apb_addr_decoder (combinational): req_addr -> {hit, psel_onehot[3:0]}.
//  Top: FSM + address/data/response registers.
// TESTING
//  1 Write 0x8000_0010 data 0xDEAD_BEEF -> PSELx=0001 T+1, PENABLE=1 T+2,
//    PWDATA stable both cycles, rsp_valid T+3 rsp_err=0 rsp_rdata=0.
//  2 Read 0x8C00_0004, PRDATA=0x1234_5678 in ACCESS -> PSELx=1000,
//    PWRITE=0, rsp_rdata=0x1234_5678 at T+3.
//  3 Back-to-back write 0x8400_0000 then read 0x8800_0000, req_valid held ->
//    PSELx 0010,0010,0100,0100; req_ready 1,0,1,0; two rsp pulses 2 cycles apart.
//  4 Read 0x9000_0000 and 0x7FFF_FFFC -> no PSELx, rsp_err=1 at T+2; write to
//    valid slave in ACCESS followed by miss -> ok rsp then err rsp, consecutive.
//  5 Hresetn low during ACCESS -> PSELx=0,PENABLE=0 before next edge, no
//    rsp_valid, next request after release completes normally.
//  6 req_valid with changing req_addr while in SETUP -> ignored, APB signals
//    unchanged; assertion: PENABLE implies |PSELx and $onehot0(PSELx) always.

Source files
------------

// File: rtl/apb_ctrl_pkg.sv
// Shared types and constants for the APB transfer controller of the AHB-to-APB bridge.
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    ERR    = 2'd3
  } apb_state_e;

  localparam int unsigned NUM_SLV       = 4;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
  localparam int unsigned DEF_SLV_SHIFT = 26;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational decode of a byte address into a window hit flag and a one-hot APB slave select.
module apb_addr_decoder
  import apb_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned SLV_SHIFT = DEF_SLV_SHIFT
) (
  input  logic [31:0]        req_addr,
  output logic               hit,
  output logic [NUM_SLV-1:0] psel_onehot
);

  // Window bounds are 33 bits wide so a window ending at 4 GB cannot wrap to zero.
  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'(NUM_SLV) << SLV_SHIFT);

  logic [32:0] addr_ext_s;
  logic [31:0] slot_s;

  // Range compare, then select the slave whose region holds the address.
  always_comb begin
    addr_ext_s = {1'b0, req_addr};
    hit        = (addr_ext_s >= WIN_LO) && (addr_ext_s < WIN_HI);
    slot_s     = (req_addr - BASE_ADDR) >> SLV_SHIFT;
    for (int i = 0; i < NUM_SLV; i++) begin
      psel_onehot[i] = hit && (slot_s == 32'(i));
    end
  end

endmodule

// File: rtl/apb_xfer_controller_chk.sv
// Protocol checker for the APB side and response port of apb_xfer_controller.
module apb_xfer_controller_chk (
  input logic       clock,
  input logic       Hresetn,
  input logic [3:0] PSELx,
  input logic       PENABLE,
  input logic       rsp_valid,
  input logic       rsp_err
);

  a_penable_needs_sel: assert property (@(posedge clock) disable iff (!Hresetn)
    PENABLE |-> (|PSELx));

  a_psel_onehot0: assert property (@(posedge clock) disable iff (!Hresetn)
    $onehot0(PSELx));

  a_err_with_valid: assert property (@(posedge clock) disable iff (!Hresetn)
    rsp_err |-> rsp_valid);

endmodule

// File: rtl/apb_xfer_controller.sv
// Sequences single read/write commands into APB SETUP/ACCESS phases and returns
// read data or a decode error as a one-cycle response pulse.
module apb_xfer_controller
  import apb_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned SLV_SHIFT = DEF_SLV_SHIFT
) (
  input  logic               clock,
  input  logic               Hresetn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic [31:0]        rsp_rdata,
  output logic [31:0]        PADDR,
  output logic               PWRITE,
  output logic [31:0]        PWDATA,
  output logic [NUM_SLV-1:0] PSELx,
  output logic               PENABLE,
  input  logic [31:0]        PRDATA
);

  apb_state_e         state_q,     state_d;
  logic [31:0]        paddr_q,     paddr_d;
  logic               pwrite_q,    pwrite_d;
  logic [31:0]        pwdata_q,    pwdata_d;
  logic [NUM_SLV-1:0] psel_q,      psel_d;
  logic               penable_q,   penable_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q,   rsp_err_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;

  logic               hit_s;
  logic [NUM_SLV-1:0] psel_dec_s;
  logic               accept_s;

  apb_addr_decoder #(
    .BASE_ADDR (BASE_ADDR),
    .SLV_SHIFT (SLV_SHIFT)
  ) u_decoder (
    .req_addr    (req_addr),
    .hit         (hit_s),
    .psel_onehot (psel_dec_s)
  );

  // SETUP is the only state that cannot take a new command.
  assign req_ready = (state_q != SETUP);
  assign accept_s  = req_valid & req_ready;

  // Next-state, APB phase and response computation.
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    psel_d      = psel_q;
    penable_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0000_0000;

    case (state_q)
      ACCESS: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = pwrite_q ? 32'h0000_0000 : PRDATA;
      end
      ERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end
      IDLE, SETUP: begin
        rsp_valid_d = 1'b0;
      end
      default: begin
        rsp_valid_d = 1'b0;
      end
    endcase

    // IDLE, ACCESS and ERR share one acceptance path, giving back-to-back transfers.
    if (state_q == SETUP) begin
      state_d   = ACCESS;
      penable_d = 1'b1;
    end else if (accept_s && hit_s) begin
      state_d  = SETUP;
      paddr_d  = req_addr;
      pwrite_d = req_write;
      pwdata_d = req_wdata;
      psel_d   = psel_dec_s;
    end else if (accept_s) begin
      state_d = ERR;
      psel_d  = {NUM_SLV{1'b0}};
    end else begin
      state_d = IDLE;
      psel_d  = {NUM_SLV{1'b0}};
    end
  end

  // State and output registers; reset drops PSELx/PENABLE without waiting for a clock.
  always_ff @(posedge clock or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q     <= IDLE;
      paddr_q     <= 32'h0000_0000;
      pwrite_q    <= 1'b0;
      pwdata_q    <= 32'h0000_0000;
      psel_q      <= {NUM_SLV{1'b0}};
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSELx     = psel_q;
  assign PENABLE   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
